line_pixel_writer: RTL and testbench
====================================

LINE_PIXEL_WRITER -- requirements
Module: line_pixel_writer

Interface
REQ-001 Parameter WIDTH_BITS, default 6, screen is 2^WIDTH_BITS x 2^WIDTH_BITS pixels, coordinates signed WIDTH_BITS+1 bits.
REQ-002 Parameter COLOR_BITS, default 8, pixel color width.
REQ-003 Parameter FIFO_DEPTH_BITS, default 3, FIFO holds 2^FIFO_DEPTH_BITS entries.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 valid  input  1  pixel strobe from line generator; no backpressure, one pixel per cycle max.
REQ-007 x, y  input  WIDTH_BITS+1 each  signed pixel coordinates, qualified by valid.
REQ-008 color_in  input  COLOR_BITS  pixel color, qualified by valid.
REQ-009 src_busy  input  1  line generator busy flag.
REQ-010 clear  input  1  synchronous clear of counters and overflow.
REQ-011 mem_we  output  1  framebuffer write request.
REQ-012 mem_addr  output  2*WIDTH_BITS  framebuffer address {y[WIDTH_BITS-1:0], x[WIDTH_BITS-1:0]}.
REQ-013 mem_data  output  COLOR_BITS  write data.
REQ-014 mem_ready  input  1  framebuffer accepts write this cycle.
REQ-015 done  output  1  one-cycle pulse: line finished and all pixels written.
REQ-016 overflow  output  1  sticky: pixel dropped on full FIFO.
REQ-017 write_count, clip_count  output  16 each  saturating counts of pixels written / clipped.

Function
REQ-018 Stage 1 register SHALL capture valid, x, y, color_in every cycle.
REQ-019 Stage-1 pixel in-bounds iff 0 <= x <= 2^WIDTH_BITS-1 and 0 <= y <= 2^WIDTH_BITS-1 (sign bit clear on both).
REQ-020 Out-of-bounds valid stage-1 pixel SHALL be discarded and clip_count incremented, saturating at 16'hFFFF.
REQ-021 In-bounds valid stage-1 pixel SHALL be pushed as {addr, color} if FIFO not full, or if full and a pop occurs the same cycle (occupancy unchanged).
REQ-022 In-bounds pixel arriving when full with no same-cycle pop SHALL be dropped and overflow set to 1; not counted in either counter.
REQ-023 Pop occurs on a cycle with mem_we=1 and mem_ready=1; write_count increments, saturating.
REQ-024 mem_we SHALL equal FIFO non-empty; mem_addr/mem_data SHALL present FIFO head and stay stable while mem_we=1 and mem_ready=0.
REQ-025 Latency: valid sampled at edge N -> FIFO write at edge N+1 -> mem_we=1 after edge N+1 when FIFO was empty.
REQ-026 FIFO order SHALL be preserved; sustained throughput one pixel per cycle while mem_ready=1.
REQ-027 State machine IDLE/ACTIVE/DRAIN: IDLE->ACTIVE when src_busy=1; ACTIVE->DRAIN when src_busy=0.
REQ-028 DRAIN->IDLE when stage-1 valid=0 and FIFO empty; done=1 for exactly that cycle transition (registered, one cycle).
REQ-029 DRAIN->ACTIVE without done if src_busy=1 again.
REQ-030 clear SHALL zero write_count, clip_count, overflow; clear wins over same-cycle increment or overflow set; FIFO and state untouched.

Reset
REQ-031 reset SHALL empty FIFO and stage 1, set state IDLE, and drive mem_we=0, mem_addr=0, mem_data=0, done=0, overflow=0, write_count=0, clip_count=0.
REQ-032 reset mid-line SHALL discard pending pixels with no further mem_we and no done pulse; reset takes priority over clear and all inputs.

Verification
REQ-033 Line (0,0)->(3,3), color 8'h5A, mem_ready=1 -> writes addr 0,65,130,195 data 8'h5A in order, first mem_we after edge N+1, write_count=4, one done pulse.
REQ-034 Pixels x=-1,y=2 and x=64,y=0 and x=5,y=5 -> clip_count=2, single write addr 325, write_count=1.
REQ-035 mem_ready=0 while 10 consecutive in-bounds pixels arrive, depth 8 -> 8 written after release in order, overflow=1, write_count=8; mem_addr stable during stall.
REQ-036 FIFO full, mem_ready=1, new pixel arriving -> accepted (push+pop), overflow stays 0.
REQ-037 src_busy falls with 3 pixels queued -> done asserted one cycle after last write pops, not earlier; src_busy re-high in DRAIN -> no done.
REQ-038 reset asserted with 4 pixels queued -> next cycle mem_we=0, counters 0, no done; clear with concurrent pop -> write_count=0.

Source files
------------

// File: rtl/line_pixel_writer_if.sv
// Pixel-in and framebuffer-write bundle for line_pixel_writer.
// The slave side is the writer; the master side is the source plus memory.
interface line_pixel_writer_if #(
  parameter int WIDTH_BITS = 6,
  parameter int COLOR_BITS = 8
);
  logic                    valid;
  logic [WIDTH_BITS:0]     x;
  logic [WIDTH_BITS:0]     y;
  logic [COLOR_BITS-1:0]   color_in;
  logic                    mem_we;
  logic [2*WIDTH_BITS-1:0] mem_addr;
  logic [COLOR_BITS-1:0]   mem_data;
  logic                    mem_ready;

  modport master (
    output valid, x, y, color_in, mem_ready,
    input  mem_we, mem_addr, mem_data
  );

  modport slave (
    input  valid, x, y, color_in, mem_ready,
    output mem_we, mem_addr, mem_data
  );
endinterface

// File: rtl/line_pixel_writer.sv
// Clips line pixels, queues them in a FIFO and writes them to a framebuffer.
// Tracks line activity to emit a done pulse once the queue has drained.
module line_pixel_writer #(
  parameter int WIDTH_BITS      = 6,
  parameter int COLOR_BITS      = 8,
  parameter int FIFO_DEPTH_BITS = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  line_pixel_writer_if.slave   bus,
  input  logic                 src_busy,
  input  logic                 clear,
  output logic                 done,
  output logic                 overflow,
  output logic [15:0]          write_count,
  output logic [15:0]          clip_count
);
  localparam int AW    = 2 * WIDTH_BITS;
  localparam int EW    = AW + COLOR_BITS;
  localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam int CW    = FIFO_DEPTH_BITS + 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

  state_t state_q, state_d;

  logic                  s1_valid_q;
  logic [WIDTH_BITS:0]   s1_x_q;
  logic [WIDTH_BITS:0]   s1_y_q;
  logic [COLOR_BITS-1:0] s1_color_q;

  logic [EW-1:0]              fifo_mem [DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]              cnt_q, cnt_d;

  logic [15:0] wcnt_q, wcnt_d;
  logic [15:0] ccnt_q, ccnt_d;
  logic        ovf_q, ovf_d;
  logic        done_q, done_d;

  logic          in_bounds, empty, full;
  logic          pop, push, drop, clip;
  logic [EW-1:0] head;

  assign in_bounds = ~s1_x_q[WIDTH_BITS] & ~s1_y_q[WIDTH_BITS];
  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == CW'(DEPTH));
  assign pop       = ~empty & bus.mem_ready;
  assign push      = s1_valid_q & in_bounds & (~full | pop);
  assign drop      = s1_valid_q & in_bounds & full & ~pop;
  assign clip      = s1_valid_q & ~in_bounds;
  assign head      = fifo_mem[rd_ptr_q];

  // Gate the head so the bus reads zero whenever nothing is queued.
  assign bus.mem_we   = ~empty;
  assign bus.mem_addr = empty ? '0 : head[EW-1:COLOR_BITS];
  assign bus.mem_data = empty ? '0 : head[COLOR_BITS-1:0];

  assign done        = done_q;
  assign overflow    = ovf_q;
  assign write_count = wcnt_q;
  assign clip_count  = ccnt_q;

  always_comb begin
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    wcnt_d = wcnt_q;
    ccnt_d = ccnt_q;
    ovf_d  = ovf_q | drop;
    if (pop && wcnt_q != 16'hFFFF) wcnt_d = wcnt_q + 16'd1;
    if (clip && ccnt_q != 16'hFFFF) ccnt_d = ccnt_q + 16'd1;
    if (clear) begin
      wcnt_d = '0;
      ccnt_d = '0;
      ovf_d  = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE:   if (src_busy) state_d = ACTIVE;
      ACTIVE: if (!src_busy) state_d = DRAIN;
      DRAIN: begin
        if (src_busy) begin
          state_d = ACTIVE;
        end else if (!s1_valid_q && empty) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {s1_y_q[WIDTH_BITS-1:0],
                             s1_x_q[WIDTH_BITS-1:0],
                             s1_color_q};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_color_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      wcnt_q     <= '0;
      ccnt_q     <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      s1_valid_q <= bus.valid;
      s1_x_q     <= bus.x;
      s1_y_q     <= bus.y;
      s1_color_q <= bus.color_in;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q      <= cnt_d;
      wcnt_q     <= wcnt_d;
      ccnt_q     <= ccnt_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end
endmodule

// File: tb/tb_line_pixel_writer.sv
// Directed bench for line_pixel_writer with a queue-based reference model.
// The model is compared against the DUT on every falling edge.
module tb_line_pixel_writer;
  localparam int W  = 6;
  localparam int C  = 8;
  localparam int FB = 3;
  localparam int D  = 1 << FB;
  localparam int SZ = 1 << W;

  logic        clk = 1'b0;
  logic        reset, src_busy, clear;
  logic        done, overflow;
  logic [15:0] write_count, clip_count;

  int tests = 0;
  int fails = 0;

  line_pixel_writer_if #(.WIDTH_BITS(W), .COLOR_BITS(C)) bus ();

  line_pixel_writer #(
    .WIDTH_BITS(W), .COLOR_BITS(C), .FIFO_DEPTH_BITS(FB)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .src_busy(src_busy), .clear(clear), .done(done),
    .overflow(overflow), .write_count(write_count),
    .clip_count(clip_count)
  );

  always #5 clk = ~clk;

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: a queue of pending writes plus line-activity mode
  int mq_addr[$];
  int mq_data[$];
  bit m_s1v;
  int m_s1x, m_s1y, m_s1c;
  int m_wc, m_cc, m_mode;
  bit m_ovf, m_done, m_full, m_pop;

  always @(posedge clk) begin
    if (reset) begin
      mq_addr.delete();
      mq_data.delete();
      m_s1v = 0; m_wc = 0; m_cc = 0; m_mode = 0;
      m_ovf = 0; m_done = 0;
    end else begin
      m_done = (m_mode == 2) && !src_busy && !m_s1v
               && mq_addr.size() == 0;
      case (m_mode)
        0: if (src_busy) m_mode = 1;
        1: if (!src_busy) m_mode = 2;
        default:
          if (src_busy) m_mode = 1;
          else if (!m_s1v && mq_addr.size() == 0) m_mode = 0;
      endcase
      m_full = mq_addr.size() == D;
      m_pop  = mq_addr.size() > 0 && bus.mem_ready;
      if (m_pop) begin
        void'(mq_addr.pop_front());
        void'(mq_data.pop_front());
        if (m_wc < 65535) m_wc++;
      end
      if (m_s1v) begin
        if (m_s1x < 0 || m_s1x >= SZ || m_s1y < 0 || m_s1y >= SZ) begin
          if (m_cc < 65535) m_cc++;
        end else if (!m_full || m_pop) begin
          mq_addr.push_back(m_s1y * SZ + m_s1x);
          mq_data.push_back(m_s1c);
        end else begin
          m_ovf = 1;
        end
      end
      if (clear) begin
        m_wc = 0; m_cc = 0; m_ovf = 0;
      end
      m_s1v = bus.valid;
      m_s1x = $signed(bus.x);
      m_s1y = $signed(bus.y);
      m_s1c = bus.color_in;
    end
  end

  int wlog[$];
  int done_cnt = 0;
  int ncyc = 0;
  int last_wr_cyc = 0;
  int done_cyc = 0;

  always @(negedge clk) begin
    ncyc++;
    check("mem_we", int'(bus.mem_we), int'(mq_addr.size() != 0));
    if (mq_addr.size() != 0) begin
      check("mem_addr", int'(bus.mem_addr), mq_addr[0]);
      check("mem_data", int'(bus.mem_data), mq_data[0]);
    end
    check("write_count", int'(write_count), m_wc);
    check("clip_count", int'(clip_count), m_cc);
    check("overflow", int'(overflow), int'(m_ovf));
    check("done", int'(done), int'(m_done));
    if (bus.mem_we && bus.mem_ready && !reset) begin
      wlog.push_back(int'(bus.mem_addr));
      last_wr_cyc = ncyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = ncyc;
    end
  end

  task automatic cyc(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic px(int xx, int yy, int cc);
    bus.valid    = 1'b1;
    bus.x        = (W + 1)'(xx);
    bus.y        = (W + 1)'(yy);
    bus.color_in = C'(cc);
    cyc();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
  endtask

  int e1[4] = '{0, 65, 130, 195};
  int d0;

  initial begin
    reset = 1'b1; src_busy = 1'b0; clear = 1'b0;
    bus.valid = 1'b0; bus.x = '0; bus.y = '0;
    bus.color_in = '0; bus.mem_ready = 1'b0;
    cyc(2);
    reset = 1'b0;
    check("rst_mem_we", int'(bus.mem_we), 0);
    check("rst_addr", int'(bus.mem_addr), 0);
    check("rst_wc", int'(write_count), 0);

    // Diagonal line with latency probe
    bus.mem_ready = 1'b1; src_busy = 1'b1;
    d0 = done_cnt;
    cyc();
    px(0, 0, 8'h5A);
    check("lat_edge_n", int'(bus.mem_we), 0);
    px(1, 1, 8'h5A);
    check("lat_edge_n1", int'(bus.mem_we), 1);
    px(2, 2, 8'h5A);
    px(3, 3, 8'h5A);
    bus.valid = 1'b0; src_busy = 1'b0;
    cyc(8);
    check("t1_wc", int'(write_count), 4);
    check("t1_nwr", wlog.size(), 4);
    for (int i = 0; i < 4; i++)
      check("t1_addr", i < wlog.size() ? wlog[i] : -1, e1[i]);
    check("t1_done", done_cnt - d0, 1);

    // Clipping
    do_clear();
    wlog.delete();
    px(-1, 2, 8'h11);
    px(64, 0, 8'h22);
    px(5, 5, 8'h33);
    bus.valid = 1'b0;
    cyc(6);
    check("t2_cc", int'(clip_count), 2);
    check("t2_wc", int'(write_count), 1);
    check("t2_addr", wlog.size() > 0 ? wlog[0] : -1, 325);

    // Stall with overflow
    do_clear();
    wlog.delete();
    bus.mem_ready = 1'b0; src_busy = 1'b1;
    d0 = done_cnt;
    for (int i = 0; i < 10; i++) px(i, 1, i + 1);
    bus.valid = 1'b0;
    cyc(2);
    check("t3_stall_a", int'(bus.mem_addr), 64);
    cyc(3);
    check("t3_stall_b", int'(bus.mem_addr), 64);
    check("t3_ovf", int'(overflow), 1);
    bus.mem_ready = 1'b1; src_busy = 1'b0;
    cyc(14);
    check("t3_wc", int'(write_count), 8);
    check("t3_nwr", wlog.size(), 8);
    for (int i = 0; i < 8; i++)
      check("t3_addr", i < wlog.size() ? wlog[i] : -1, 64 + i);
    check("t3_done", done_cnt - d0, 1);

    // Full FIFO accepts when a pop happens the same cycle
    do_clear();
    wlog.delete();
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 9; i++) px(i, 2, 8'h40 + i);
    bus.valid = 1'b0; bus.mem_ready = 1'b1;
    cyc();
    check("t4_ovf0", int'(overflow), 0);
    cyc(12);
    check("t4_ovf1", int'(overflow), 0);
    check("t4_wc", int'(write_count), 9);
    check("t4_last", wlog.size() == 9 ? wlog[8] : -1, 136);

    // Drain timing and re-activation in DRAIN
    do_clear();
    bus.mem_ready = 1'b0; src_busy = 1'b1;
    d0 = done_cnt;
    cyc();
    for (int i = 0; i < 3; i++) px(i, 3, 8'h70);
    bus.valid = 1'b0; src_busy = 1'b0;
    cyc(4);
    check("t5_nodone", done_cnt - d0, 0);
    src_busy = 1'b1;
    cyc();
    src_busy = 1'b0; bus.mem_ready = 1'b1;
    cyc(10);
    check("t5_done", done_cnt - d0, 1);
    check("t5_gap", done_cyc - last_wr_cyc, 2);
    check("t5_wc", int'(write_count), 3);

    // Reset mid-line
    bus.mem_ready = 1'b0; src_busy = 1'b1;
    for (int i = 0; i < 4; i++) px(i, 4, 8'h0F);
    bus.valid = 1'b0;
    cyc();
    d0 = done_cnt;
    reset = 1'b1; src_busy = 1'b0;
    cyc();
    reset = 1'b0;
    check("t6_we", int'(bus.mem_we), 0);
    check("t6_wc", int'(write_count), 0);
    check("t6_cc", int'(clip_count), 0);
    cyc(5);
    check("t6_nodone", done_cnt - d0, 0);
    check("t6_we2", int'(bus.mem_we), 0);

    // Clear while a pop is happening
    for (int i = 0; i < 3; i++) px(i, 6, 8'h21);
    bus.valid = 1'b0;
    cyc();
    bus.mem_ready = 1'b1;
    cyc();
    check("t7_wc1", int'(write_count), 1);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    check("t7_clr", int'(write_count), 0);
    cyc(5);
    check("t7_wc2", int'(write_count), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
